csr_file: RTL and testbench

Machine-mode CSR register file for the RV32I core. It holds all implemented M-mode CSRs and drives `csr_rdata` combinationally to the CSR ALU. It commits the ALU's `csr_wdata`/`csr_we` on the clock edge, maintains the 64-bit cycle and instret counters, and performs the trap-entry and `mret` state updates that come from the control unit.

---
 rtl/csr_file_pkg.sv | 44 ++++
 rtl/csr_counter64.sv | 31 +++
 rtl/csr_file.sv | 152 +++++++++++++++
 tb/tb_csr_file.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_file_pkg.sv
// csr_file_pkg: shared CSR address map, mstatus field positions and constant
// values used by the machine-mode CSR file and its counters.
package csr_file_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNT_W = 2 * XLEN;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MISA      = 12'h301,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MTVAL     = 12'h343,
    CSR_MIP       = 12'h344,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_CYCLE     = 12'hC00,
    CSR_INSTRET   = 12'hC02,
    CSR_CYCLEH    = 12'hC80,
    CSR_INSTRETH  = 12'hC82,
    CSR_MVENDORID = 12'hF11,
    CSR_MARCHID   = 12'hF12,
    CSR_MIMPID    = 12'hF13,
    CSR_MHARTID   = 12'hF14
  } csr_addr_t;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam int unsigned IRQ_SW_BIT    = 3;
  localparam int unsigned IRQ_TIMER_BIT = 7;
  localparam int unsigned IRQ_EXT_BIT   = 11;

  localparam logic [XLEN-1:0] MISA_VAL = 32'h4000_0100;
  localparam logic [XLEN-1:0] IRQ_MASK = 32'h0000_0888;

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit free counter with increment enable and separate
// low/high half write ports.
// Ports: clk, rst (sync, active-high), inc (increment enable),
//        we_lo/we_hi (half write strobes), wdata (write data), value (count).
module csr_counter64
  import csr_file_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             we_lo,
  input  logic             we_hi,
  input  logic [XLEN-1:0]  wdata,
  output logic [CNT_W-1:0] value
);

  // A low write suppresses the increment; a high write keeps counting the
  // low half but never carries into the freshly written high half.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (we_lo) begin
      value <= {value[CNT_W-1:XLEN], wdata};
    end else if (we_hi) begin
      value <= {wdata, value[XLEN-1:0] + XLEN'(inc)};
    end else begin
      value <= value + CNT_W'(inc);
    end
  end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file. Combinational read port, committed
// writes, 64-bit mcycle/minstret, trap-entry and mret mstatus/mepc updates.
// Ports: clk, rst (sync, active-high); csr_addr/csr_rdata read port;
//        csr_wdata/csr_we/csr_commit write port; csr_illegal access fault;
//        instr_retire; trap_enter/trap_pc/trap_cause/trap_tval; mret;
//        irq_sw/irq_timer/irq_ext level interrupts; mtvec_o, mepc_o, irq_pending.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_rdata,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            csr_we,
  input  logic            csr_commit,
  output logic            csr_illegal,
  input  logic            instr_retire,
  input  logic            trap_enter,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            irq_ext,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending
);

  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [CNT_W-1:0] mcycle;
  logic [CNT_W-1:0] minstret;

  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] mip_val;
  logic            implemented;
  logic            wr;

  // Assembled read views of mstatus and mip.
  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_val[MSTATUS_MPIE] = mstatus_mpie;
    mstatus_val[MSTATUS_MIE]  = mstatus_mie;
    mip_val = '0;
    mip_val[IRQ_SW_BIT]    = irq_sw;
    mip_val[IRQ_TIMER_BIT] = irq_timer;
    mip_val[IRQ_EXT_BIT]   = irq_ext;
  end

  // Read mux and implemented-address decode.
  always_comb begin
    csr_rdata   = '0;
    implemented = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:                csr_rdata = mstatus_val;
      CSR_MISA:                   csr_rdata = MISA_VAL;
      CSR_MIE:                    csr_rdata = mie_q;
      CSR_MTVEC:                  csr_rdata = mtvec_q;
      CSR_MSCRATCH:               csr_rdata = mscratch_q;
      CSR_MEPC:                   csr_rdata = mepc_q;
      CSR_MCAUSE:                 csr_rdata = mcause_q;
      CSR_MTVAL:                  csr_rdata = mtval_q;
      CSR_MIP:                    csr_rdata = mip_val;
      CSR_MCYCLE,    CSR_CYCLE:    csr_rdata = mcycle[XLEN-1:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   csr_rdata = mcycle[CNT_W-1:XLEN];
      CSR_MINSTRET,  CSR_INSTRET:  csr_rdata = minstret[XLEN-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret[CNT_W-1:XLEN];
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_rdata = '0;
      CSR_MHARTID:                csr_rdata = HART_ID;
      default:                    implemented = 1'b0;
    endcase
  end

  assign csr_illegal = ~implemented | (csr_we & (csr_addr[11:10] == 2'b11));
  assign wr          = csr_we & csr_commit & ~csr_illegal;
  assign irq_pending = mstatus_mie & (|(mie_q & mip_val));
  assign mtvec_o     = mtvec_q;
  assign mepc_o      = mepc_q;

  // Trap entry outranks mret, which outranks a CSR write to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= RESET_MTVEC;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else begin
      if (trap_enter) begin
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr && (csr_addr == CSR_MSTATUS)) begin
        mstatus_mie  <= csr_wdata[MSTATUS_MIE];
        mstatus_mpie <= csr_wdata[MSTATUS_MPIE];
      end

      if (trap_enter) begin
        mepc_q   <= trap_pc & ~32'h3;
        mcause_q <= trap_cause;
        mtval_q  <= trap_tval;
      end else begin
        if (wr && (csr_addr == CSR_MEPC))   mepc_q   <= csr_wdata & ~32'h3;
        if (wr && (csr_addr == CSR_MCAUSE)) mcause_q <= csr_wdata;
        if (wr && (csr_addr == CSR_MTVAL))  mtval_q  <= csr_wdata;
      end

      if (wr && (csr_addr == CSR_MIE))      mie_q      <= csr_wdata & IRQ_MASK;
      if (wr && (csr_addr == CSR_MTVEC))    mtvec_q    <= csr_wdata & ~32'h3;
      if (wr && (csr_addr == CSR_MSCRATCH)) mscratch_q <= csr_wdata;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .we_lo (wr && (csr_addr == CSR_MCYCLE)),
    .we_hi (wr && (csr_addr == CSR_MCYCLEH)),
    .wdata (csr_wdata),
    .value (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_retire),
    .we_lo (wr && (csr_addr == CSR_MINSTRET)),
    .we_hi (wr && (csr_addr == CSR_MINSTRETH)),
    .wdata (csr_wdata),
    .value (minstret)
  );

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: self-checking bench for csr_file. Table of write/read-back
// vectors, hand-written multi-cycle sequences, then randomized traffic
// checked against a behavioural model of the CSR rules.
module tb_csr_file;

  localparam logic [31:0] HART   = 32'h0000_0005;
  localparam logic [31:0] RMTVEC = 32'h8000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_rdata;
  logic [31:0] csr_wdata = '0;
  logic        csr_we = 1'b0;
  logic        csr_commit = 1'b0;
  logic        csr_illegal;
  logic        instr_retire = 1'b0;
  logic        trap_enter = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_tval = '0;
  logic        mret = 1'b0;
  logic        irq_sw = 1'b0;
  logic        irq_timer = 1'b0;
  logic        irq_ext = 1'b0;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        irq_pending;

  csr_file #(.HART_ID(HART), .RESET_MTVEC(RMTVEC)) dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_rdata(csr_rdata),
    .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_commit(csr_commit),
    .csr_illegal(csr_illegal), .instr_retire(instr_retire),
    .trap_enter(trap_enter), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .trap_tval(trap_tval), .mret(mret), .irq_sw(irq_sw),
    .irq_timer(irq_timer), .irq_ext(irq_ext), .mtvec_o(mtvec_o),
    .mepc_o(mepc_o), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_mie_b, m_mpie;
  bit [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  bit [63:0] m_cyc, m_ins;

  function automatic bit [31:0] m_mip();
    return {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
  endfunction

  function automatic bit [31:0] m_mstatus();
    return 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie_b) << 3);
  endfunction

  function automatic bit m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80,
      12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [31:0] m_val(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus();
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip();
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      12'hF14: return HART;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_illegal();
    return !m_impl(csr_addr) || (csr_we && csr_addr[11:10] == 2'b11);
  endfunction

  function automatic bit m_pending();
    return m_mie_b && ((m_mie & m_mip()) != 0);
  endfunction

  // Next state from the current inputs, applied just before the clock edge.
  task automatic model_update();
    bit [31:0] wd;
    bit [11:0] a;
    bit        wr;
    bit        old_mie;
    wd = csr_wdata;
    a  = csr_addr;
    wr = csr_we && csr_commit && !m_illegal();
    if (rst) begin
      m_mie_b = 0; m_mpie = 0; m_mie = 0; m_mtvec = RMTVEC; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
      return;
    end
    if (wr && a == 12'hB00)      m_cyc = {m_cyc[63:32], wd};
    else if (wr && a == 12'hB80) m_cyc = {wd, m_cyc[31:0] + 32'd1};
    else                         m_cyc = m_cyc + 64'd1;
    if (wr && a == 12'hB02)      m_ins = {m_ins[63:32], wd};
    else if (wr && a == 12'hB82) m_ins = {wd, m_ins[31:0] + 32'(instr_retire)};
    else                         m_ins = m_ins + 64'(instr_retire);
    old_mie = m_mie_b;
    if (trap_enter) begin
      m_mpie = old_mie; m_mie_b = 0;
      m_mepc = trap_pc & 32'hFFFF_FFFC; m_mcause = trap_cause; m_mtval = trap_tval;
    end else begin
      if (mret) begin
        m_mie_b = m_mpie; m_mpie = 1;
      end else if (wr && a == 12'h300) begin
        m_mie_b = wd[3]; m_mpie = wd[7];
      end
      if (wr && a == 12'h341) m_mepc = wd & 32'hFFFF_FFFC;
      if (wr && a == 12'h342) m_mcause = wd;
      if (wr && a == 12'h343) m_mtval = wd;
    end
    if (wr && a == 12'h304) m_mie = wd & 32'h0000_0888;
    if (wr && a == 12'h305) m_mtvec = wd & 32'hFFFF_FFFC;
    if (wr && a == 12'h340) m_mscratch = wd;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_read(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check32(name, csr_rdata, exp);
  endtask

  task automatic set_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr = a; csr_wdata = d; csr_we = 1'b1; csr_commit = 1'b1;
  endtask

  task automatic clr_write();
    csr_we = 1'b0; csr_commit = 1'b0;
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exp_ill;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t tbl[14];

  logic [11:0] addr_pool[28];

  initial begin
    tbl[0]  = '{12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0000_1888, "mstatus_ones"};
    tbl[1]  = '{12'h300, 32'h0000_0000, 1'b0, 32'h0000_1800, "mstatus_zero"};
    tbl[2]  = '{12'h301, 32'hFFFF_FFFF, 1'b0, 32'h4000_0100, "misa_ro"};
    tbl[3]  = '{12'h304, 32'hFFFF_FFFF, 1'b0, 32'h0000_0888, "mie_mask"};
    tbl[4]  = '{12'h305, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, "mtvec_mask"};
    tbl[5]  = '{12'h340, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, "mscratch"};
    tbl[6]  = '{12'h341, 32'h1234_5677, 1'b0, 32'h1234_5674, "mepc_mask"};
    tbl[7]  = '{12'h342, 32'h8000_000B, 1'b0, 32'h8000_000B, "mcause"};
    tbl[8]  = '{12'h343, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, "mtval"};
    tbl[9]  = '{12'h344, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, "mip_ro"};
    tbl[10] = '{12'hF14, 32'h0000_0077, 1'b1, HART,          "mhartid_ro"};
    tbl[11] = '{12'hF11, 32'h0000_0077, 1'b1, 32'h0000_0000, "mvendorid_ro"};
    tbl[12] = '{12'h7C0, 32'h0000_0077, 1'b1, 32'h0000_0000, "unimpl_7c0"};
    tbl[13] = '{12'hF12, 32'h1111_1111, 1'b1, 32'h0000_0000, "marchid_ro"};

    addr_pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                  12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00,
                  12'hC02, 12'hC80, 12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14,
                  12'h7C0, 12'h000, 12'h302, 12'h3A0, 12'hC01, 12'hF15, 12'hB01};

    // Reset and first-cycle values.
    tick();
    tick();
    rst = 1'b0;
    chk_read("rst_mstatus", 12'h300, 32'h0000_1800);
    chk_read("rst_mtvec", 12'h305, RMTVEC);
    chk_read("rst_mcycle", 12'hB00, 32'h0);
    chk_read("rst_mhartid", 12'hF14, HART);
    check32("rst_irq_pending", 32'(irq_pending), 32'h0);
    check32("rst_mtvec_o", mtvec_o, RMTVEC);
    check32("rst_mepc_o", mepc_o, 32'h0);
    tick();
    tick();
    chk_read("mcycle_plus2", 12'hB00, 32'd2);
    chk_read("cycle_plus2", 12'hC00, 32'd2);
    chk_read("mcycleh_zero", 12'hB80, 32'd0);

    // Table of write then read-back vectors.
    for (int i = 0; i < 14; i++) begin
      set_write(tbl[i].addr, tbl[i].wdata);
      #1;
      check32({tbl[i].name, "_ill"}, 32'(csr_illegal), 32'(tbl[i].exp_ill));
      tick();
      clr_write();
      #1;
      check32(tbl[i].name, csr_rdata, tbl[i].exp_rd);
    end
    check32("mtvec_o_after_write", mtvec_o, 32'hFFFF_FFFC);

    // mie masking and irq_pending gating by MIE.
    set_write(12'h304, 32'hFFFF_FFFF);
    tick();
    clr_write();
    chk_read("mie_readback", 12'h304, 32'h0000_0888);
    irq_timer = 1'b1;
    #1;
    check32("pending_mie0", 32'(irq_pending), 32'h0);
    set_write(12'h300, 32'h0000_0008);
    tick();
    clr_write();
    #1;
    check32("pending_mie1", 32'(irq_pending), 32'h1);
    chk_read("mip_timer", 12'h344, 32'h0000_0080);
    irq_timer = 1'b0;
    #1;
    check32("pending_irq_low", 32'(irq_pending), 32'h0);

    // Trap entry then mret.
    trap_enter = 1'b1; trap_pc = 32'h0000_1007; trap_cause = 32'h8000_0007;
    trap_tval = 32'h0000_0BAD;
    tick();
    trap_enter = 1'b0;
    check32("trap_mepc_o", mepc_o, 32'h0000_1004);
    chk_read("trap_mepc", 12'h341, 32'h0000_1004);
    chk_read("trap_mcause", 12'h342, 32'h8000_0007);
    chk_read("trap_mtval", 12'h343, 32'h0000_0BAD);
    chk_read("trap_mstatus", 12'h300, 32'h0000_1880);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk_read("mret_mstatus", 12'h300, 32'h0000_1888);

    // Trap, mret and a mepc write together: only the trap applies.
    trap_enter = 1'b1; mret = 1'b1; trap_pc = 32'h2000_0042;
    trap_cause = 32'h0000_0002; trap_tval = 32'h0;
    set_write(12'h341, 32'h0000_0100);
    tick();
    trap_enter = 1'b0; mret = 1'b0;
    clr_write();
    chk_read("prio_mepc", 12'h341, 32'h2000_0040);
    chk_read("prio_mstatus", 12'h300, 32'h0000_1880);
    chk_read("prio_mcause", 12'h342, 32'h0000_0002);

    // mcycle set to all ones, then wraps.
    set_write(12'hB80, 32'hFFFF_FFFF);
    tick();
    set_write(12'hB00, 32'hFFFF_FFFF);
    tick();
    clr_write();
    chk_read("mcycle_ones_lo", 12'hB00, 32'hFFFF_FFFF);
    chk_read("mcycle_ones_hi", 12'hB80, 32'hFFFF_FFFF);
    tick();
    chk_read("mcycle_wrap_lo", 12'hB00, 32'h0);
    chk_read("mcycle_wrap_hi", 12'hB80, 32'h0);
    set_write(12'hC00, 32'hDEAD_0000);
    #1;
    check32("cycle_write_ill", 32'(csr_illegal), 32'h1);
    tick();
    clr_write();
    chk_read("cycle_unchanged", 12'hC00, 32'd1);

    // minstret writes alongside a retiring instruction.
    set_write(12'hB02, 32'h1234_5678);
    instr_retire = 1'b1;
    tick();
    clr_write();
    instr_retire = 1'b0;
    chk_read("minstret_exact", 12'hB02, 32'h1234_5678);
    chk_read("instret_shadow", 12'hC02, 32'h1234_5678);
    set_write(12'hB82, 32'h0000_00AB);
    instr_retire = 1'b1;
    tick();
    clr_write();
    instr_retire = 1'b0;
    chk_read("minstreth_write", 12'hB82, 32'h0000_00AB);
    chk_read("minstret_lo_inc", 12'hB02, 32'h1234_5679);

    // Illegal read and uncommitted write.
    csr_addr = 12'h7C0;
    #1;
    check32("read_7c0_ill", 32'(csr_illegal), 32'h1);
    csr_addr = 12'h340; csr_wdata = 32'h1111_1111; csr_we = 1'b1; csr_commit = 1'b0;
    tick();
    clr_write();
    chk_read("no_commit", 12'h340, 32'hDEAD_BEEF);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst          = ($urandom_range(0, 299) == 0);
      csr_addr     = addr_pool[$urandom_range(0, 27)];
      csr_wdata    = $urandom;
      csr_we       = 1'($urandom_range(0, 1));
      csr_commit   = ($urandom_range(0, 3) != 0);
      instr_retire = 1'($urandom_range(0, 1));
      trap_enter   = ($urandom_range(0, 15) == 0);
      mret         = ($urandom_range(0, 11) == 0);
      trap_pc      = $urandom;
      trap_cause   = $urandom;
      trap_tval    = $urandom;
      irq_sw       = 1'($urandom_range(0, 1));
      irq_timer    = 1'($urandom_range(0, 1));
      irq_ext      = 1'($urandom_range(0, 1));
      #1;
      check32("rnd_rdata", csr_rdata, m_val(csr_addr));
      check32("rnd_illegal", 32'(csr_illegal), 32'(m_illegal()));
      check32("rnd_pending", 32'(irq_pending), 32'(m_pending()));
      check32("rnd_mtvec_o", mtvec_o, m_mtvec);
      check32("rnd_mepc_o", mepc_o, m_mepc);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
